latch_sync_debounce: RTL and testbench

- Clocked consumer of a level-sensitive D-latch output (q). The latch output changes asynchronously to clk, whenever the latch enable is open.
- Synchronises that output into the clk domain, then debounces it with a state machine.
- Produces a clean level, single-cycle rise/fall pulses, and a rising-edge event counter for downstream clocked logic.

---
 rtl/latch_sync_pkg.sv | 16 +
 rtl/sync_ff_chain.sv | 21 ++
 rtl/latch_sync_debounce.sv | 127 ++++++++++++
 tb/tb_latch_sync_debounce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/latch_sync_pkg.sv
// Shared definitions for the latch-output synchroniser/debouncer: FSM state
// encodings and default parameter values.
package latch_sync_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/sync_ff_chain.sv
// Plain multi-flop synchroniser chain with synchronous active-high reset.
// Reusable wherever an asynchronous level must be brought into a clock domain.
module sync_ff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/latch_sync_debounce.sv
// Synchronises and debounces a latch q output; emits a clean level, rise/fall
// pulses and a rising-edge counter. Optional LATCH_SYNC_GLITCH_CNT_EN adds glitch_count.
module latch_sync_debounce
  import latch_sync_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             async_in,
  input  logic             clear_cnt,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             busy
`ifdef LATCH_SYNC_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_count
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             level_nx, rise_nx, fall_nx;
  logic [CNT_W-1:0] edge_nx;

  sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (async_in),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      edge_count <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      level_out  <= level_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
      edge_count <= edge_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level_out;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      STABLE_LO: if (s) begin
        state_nx = CHK_HI;
        cnt_nx   = CW'(1);
      end
      CHK_HI: begin
        if (!s) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
          level_nx = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STABLE_HI: if (!s) begin
        state_nx = CHK_LO;
        cnt_nx   = CW'(1);
      end
      CHK_LO: begin
        if (s) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
          level_nx = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = STABLE_LO;
        cnt_nx   = '0;
      end
    endcase
  end

  // clear_cnt wins over the old value but still counts a coincident acceptance
  always_comb begin
    edge_nx = edge_count;
    if (clear_cnt)    edge_nx = rise_nx ? CNT_W'(1) : '0;
    else if (rise_nx) edge_nx = edge_count + 1'b1;
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

`ifdef LATCH_SYNC_GLITCH_CNT_EN
  logic reject;
  assign reject = ((state == CHK_HI) && !s) || ((state == CHK_LO) && s);

  always_ff @(posedge clk) begin
    if (reset)          glitch_count <= '0;
    else if (clear_cnt) glitch_count <= reject ? CNT_W'(1) : '0;
    else if (reject)    glitch_count <= glitch_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_latch_sync_debounce.sv
// Scoreboard bench for latch_sync_debounce: stimulus pushes expected pulses,
// a negedge monitor pops and compares them; a behavioural d-latch drives async_in.
`timescale 1ns/1ps
module tb_latch_sync_debounce;

  localparam int CW_T = 2;
  localparam int LAT  = 6;  // drive cycle n -> pulse observed after edge n+6

  typedef struct {
    logic       rise;
    logic       level;
    logic [1:0] cnt;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, drv_in, clear_cnt, use_latch;
  logic lat_d, lat_en;
  logic lat_q = 1'b0;
  logic async_in;
  logic level_out, rise_pulse, fall_pulse, busy;
  logic [CW_T-1:0] edge_count;
`ifdef LATCH_SYNC_GLITCH_CNT_EN
  logic [CW_T-1:0] glitch_count;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_exp[$];

  always #500 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(lat_d or lat_en) if (lat_en) lat_q = lat_d;
  assign async_in = use_latch ? lat_q : drv_in;

  latch_sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(CW_T)) dut (
    .clk        (clk),
    .reset      (reset),
    .async_in   (async_in),
    .clear_cnt  (clear_cnt),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_count (edge_count),
    .busy       (busy)
`ifdef LATCH_SYNC_GLITCH_CNT_EN
    ,
    .glitch_count (glitch_count)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic rise, input logic [1:0] cnt, input int at);
    exp_t e;
    e.rise = rise; e.level = rise; e.cnt = cnt; e.cyc = at;
    q_exp.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drive high, hold, drive low, hold; expects one rise and one fall
  task automatic rise_fall(input int hold, input logic [1:0] cnt);
    drv_in = 1'b1; push(1'b1, cnt, cyc + LAT);
    tick(hold);
    drv_in = 1'b0; push(1'b0, cnt, cyc + LAT);
    tick(hold);
  endtask

  always @(negedge clk) begin
    if (rise_pulse || fall_pulse) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, none expected",
                 rise_pulse, fall_pulse, cyc);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        if (rise_pulse !== e.rise || fall_pulse !== !e.rise || level_out !== e.level ||
            edge_count !== e.cnt || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse: got rise=%0b fall=%0b level=%0b cnt=%0d cyc=%0d want rise=%0b fall=%0b level=%0b cnt=%0d cyc=%0d",
                   rise_pulse, fall_pulse, level_out, edge_count, cyc,
                   e.rise, !e.rise, e.level, e.cnt, e.cyc);
        end
      end
    end
  end

  initial begin
    #(1000 * 2000);
    $display("FAIL timeout: bench still running at cycle %0d, want finish", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; drv_in = 1'b1; clear_cnt = 1'b0; use_latch = 1'b0;
    lat_d = 1'b0; lat_en = 1'b1;
    tick(3);
    check("reset_level", level_out, 0);
    check("reset_rise", rise_pulse, 0);
    check("reset_fall", fall_pulse, 0);
    check("reset_count", edge_count, 0);
    check("reset_busy", busy, 0);
`ifdef LATCH_SYNC_GLITCH_CNT_EN
    check("reset_glitch", glitch_count, 0);
`endif
    reset = 1'b0;
    push(1'b1, 2'd1, cyc + LAT);  // edge 6 after release
    tick(3);
    check("busy_in_check", busy, 1);
    tick(6);
    check("level_after_rise", level_out, 1);
    drv_in = 1'b0; push(1'b0, 2'd1, cyc + LAT);
    tick(12);

    rise_fall(10, 2'd2);

    // glitch: two cycles high
    drv_in = 1'b1; tick(2); drv_in = 1'b0;
    tick(1);
    check("glitch_busy1", busy, 1);
    tick(1);
    check("glitch_busy2", busy, 1);
    tick(1);
    check("glitch_busy_done", busy, 0);
    check("glitch_level", level_out, 0);
`ifdef LATCH_SYNC_GLITCH_CNT_EN
    check("glitch_count1", glitch_count, 1);
`endif
    tick(1);

    rise_fall(8, 2'd3);
    rise_fall(8, 2'd0);
    rise_fall(8, 2'd1);

    // sixth acceptance coincides with clear_cnt
    drv_in = 1'b1; push(1'b1, 2'd1, cyc + LAT);
    tick(LAT - 1); clear_cnt = 1'b1;
    tick(1); clear_cnt = 1'b0;
    check("clear_and_accept", edge_count, 1);
`ifdef LATCH_SYNC_GLITCH_CNT_EN
    check("glitch_cleared", glitch_count, 0);
`endif
    tick(2);
    drv_in = 1'b0; push(1'b0, 2'd1, cyc + LAT);
    tick(10);

    // reset while a check is in progress
    drv_in = 1'b1; tick(3);
    check("midreset_busy_before", busy, 1);
    reset = 1'b1; drv_in = 1'b0;
    tick(1);
    check("midreset_busy", busy, 0);
    check("midreset_level", level_out, 0);
    check("midreset_count", edge_count, 0);
    check("midreset_rise", rise_pulse, 0);
    reset = 1'b0;
    tick(10);

    rise_fall(8, 2'd1);
    clear_cnt = 1'b1; tick(1); clear_cnt = 1'b0;
    check("clear_alone", edge_count, 0);
    tick(2);

    // latch-driven: d toggles mid-cycle with enable open
    use_latch = 1'b1;
    @(posedge clk); #200; lat_d = 1'b1; push(1'b1, 2'd1, cyc + LAT);
    repeat (10) @(posedge clk);
    #300; lat_d = 1'b0; push(1'b0, 2'd1, cyc + LAT);
    repeat (10) @(posedge clk);
    #200; lat_d = 1'b1;
    repeat (3) @(posedge clk);
    #200; lat_d = 1'b0;
    tick(6);
    check("latch_short_level", level_out, 0);
`ifdef LATCH_SYNC_GLITCH_CNT_EN
    check("latch_short_glitch", glitch_count, 1);
`endif
    // enable closed: d changes must not reach q
    lat_en = 1'b0; tick(1); lat_d = 1'b1;
    tick(10);
    check("latch_closed_level", level_out, 0);
    check("latch_count", edge_count, 1);

    tick(4);
    check("scoreboard_empty", q_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
